// File: rtl/cpu_defs.sv
// Shared CPU definitions: PC width, return stack geometry, call/return
// opcodes and the control-unit decode that turns them into stack commands.
package cpu_defs;

  localparam int PC_W         = 10;
  localparam int RSTACK_DEPTH = 16;
  localparam int RSTACK_LW    = $clog2(RSTACK_DEPTH) + 1;

  localparam logic [5:0] OP_JCALL = 6'b001011;
  localparam logic [5:0] OP_JR    = 6'b001100;

  // Occupancy view of the stack pointer
  typedef enum logic [1:0] {
    RS_EMPTY   = 2'd0,
    RS_PARTIAL = 2'd1,
    RS_FULL    = 2'd2
  } rs_state_e;

  // Stack command issued by the control unit
  typedef struct packed {
    logic push;
    logic pop;
  } rs_ctrl_t;

  // JCALL pushes the return address, JR pops it
  function automatic rs_ctrl_t rs_decode(input logic [5:0] opcode);
    rs_ctrl_t c;
    c.push = (opcode == OP_JCALL);
    c.pop  = (opcode == OP_JR);
    return c;
  endfunction

endpackage

// File: rtl/return_stack_if.sv
// Push/pop command and status bundle between control unit and return stack.
interface return_stack_if
  import cpu_defs::*;
#(
  parameter int AW = PC_W,
  parameter int LW = RSTACK_LW
) ();

  logic          push;
  logic          pop;
  logic [AW-1:0] din;
  logic [AW-1:0] dout;
  logic [LW-1:0] level;
  logic          empty;
  logic          full;
  logic          ovf;
  logic          udf;

  modport master (
    output push, pop, din,
    input  dout, level, empty, full, ovf, udf
  );

  modport slave (
    input  push, pop, din,
    output dout, level, empty, full, ovf, udf
  );

endinterface

// File: rtl/stack_mem.sv
// DEPTH x AW register array, one clocked write port, one async read port.
// Contents are deliberately not reset.
module stack_mem #(
  parameter int AW    = 10,
  parameter int DEPTH = 16,
  parameter int IW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [IW-1:0] waddr,
  input  logic [AW-1:0] wdata,
  input  logic [IW-1:0] raddr,
  output logic [AW-1:0] rdata
);

  logic [DEPTH-1:0][AW-1:0] mem;

  // Single write port
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/return_stack.sv
// Return-address LIFO for the single-cycle CPU. Top of stack is visible
// combinationally so JR can use it in the same cycle it pops.
// Optional feature macro: RSTACK_ERR_EN enables the sticky ovf/udf flags;
// without it both outputs are tied low and no flag flops exist.
module return_stack
  import cpu_defs::*;
#(
  parameter int AW    = PC_W,
  parameter int DEPTH = RSTACK_DEPTH,
  parameter int LW    = $clog2(DEPTH) + 1
) (
  input logic           clk,
  input logic           reset,
  return_stack_if.slave bus
);

  localparam int IW = $clog2(DEPTH);

  rs_ctrl_t      req;
  rs_state_e     state;
  logic [LW-1:0] sp, sp_nxt;
  logic [IW-1:0] top_idx;
  logic          we;
  logic [IW-1:0] waddr;
  logic [AW-1:0] rdata;

  assign req = '{push: bus.push, pop: bus.pop};

  // sp is the next free slot; at sp==DEPTH the low bits wrap to 0 so
  // sp-1 still lands on the last entry.
  assign top_idx = sp[IW-1:0] - IW'(1);

  // Occupancy classification from sp
  always_comb begin
    state = RS_PARTIAL;
    if (sp == '0)             state = RS_EMPTY;
    else if (sp == LW'(DEPTH)) state = RS_FULL;
  end

  // Push/pop arbitration: next sp and write port control
  always_comb begin
    sp_nxt = sp;
    we     = 1'b0;
    waddr  = sp[IW-1:0];
    case ({req.push, req.pop})
      2'b10: begin
        if (state != RS_FULL) begin
          we     = 1'b1;
          sp_nxt = sp + LW'(1);
        end
      end
      2'b01: begin
        if (state != RS_EMPTY) sp_nxt = sp - LW'(1);
      end
      2'b11: begin
        // Tail call replaces the top; on an empty stack it is a plain push
        we = 1'b1;
        if (state == RS_EMPTY) sp_nxt = sp + LW'(1);
        else                   waddr  = top_idx;
      end
      default: ;
    endcase
  end

  // Stack pointer register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) sp <= '0;
    else       sp <= sp_nxt;
  end

  // A push coinciding with reset is dropped
  stack_mem #(.AW(AW), .DEPTH(DEPTH), .IW(IW)) u_mem (
    .clk   (clk),
    .we    (we & ~reset),
    .waddr (waddr),
    .wdata (bus.din),
    .raddr (top_idx),
    .rdata (rdata)
  );

  assign bus.dout  = (state == RS_EMPTY) ? '0 : rdata;
  assign bus.level = sp;
  assign bus.empty = (state == RS_EMPTY);
  assign bus.full  = (state == RS_FULL);

`ifdef RSTACK_ERR_EN
  logic ovf_q, udf_q;
  logic ovf_set, udf_set;

  assign ovf_set = req.push & ~req.pop & (state == RS_FULL);
  assign udf_set = req.pop & ~req.push & (state == RS_EMPTY);

  // Sticky error flags, cleared only by reset
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ovf_q <= 1'b0;
      udf_q <= 1'b0;
    end else begin
      if (ovf_set) ovf_q <= 1'b1;
      if (udf_set) udf_q <= 1'b1;
    end
  end

  assign bus.ovf = ovf_q;
  assign bus.udf = udf_q;
`else
  assign bus.ovf = 1'b0;
  assign bus.udf = 1'b0;
`endif

endmodule

// File: tb/tb_return_stack.sv
// Self-checking bench for return_stack: directed vector table, hand-written
// full/empty/reset sequences and a random run against a queue-based LIFO.
module tb_return_stack;

`ifdef RSTACK_ERR_EN
  localparam bit ERR = 1'b1;
`else
  localparam bit ERR = 1'b0;
`endif

  logic clk;
  logic reset;
  int   n_checks = 0;
  int   n_err    = 0;

  return_stack_if #(.AW(10), .LW(5)) bus ();

  return_stack #(.AW(10), .DEPTH(16), .LW(5)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       push;
    logic       pop;
    logic [9:0] din;
    logic [9:0] dout;
    logic [4:0] level;
  } vec_t;

  vec_t vecs[12];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Called at a negedge; returns at the next negedge after one posedge
  task automatic step(input logic p, input logic q, input logic [9:0] d);
    bus.push = p;
    bus.pop  = q;
    bus.din  = d;
    @(negedge clk);
    bus.push = 1'b0;
    bus.pop  = 1'b0;
  endtask

  task automatic chk_state(input string name, input logic [9:0] d, input logic [4:0] l);
    chk({name, ".dout"},  32'(bus.dout),  32'(d));
    chk({name, ".level"}, 32'(bus.level), 32'(l));
    chk({name, ".empty"}, 32'(bus.empty), 32'(l == 5'd0));
    chk({name, ".full"},  32'(bus.full),  32'(l == 5'd16));
  endtask

  logic [9:0] model[$];

  initial begin
    vecs[0]  = '{1'b1, 1'b0, 10'h005, 10'h005, 5'd1};
    vecs[1]  = '{1'b1, 1'b0, 10'h012, 10'h012, 5'd2};
    vecs[2]  = '{1'b1, 1'b0, 10'h3FF, 10'h3FF, 5'd3};
    vecs[3]  = '{1'b0, 1'b1, 10'h000, 10'h012, 5'd2};
    vecs[4]  = '{1'b0, 1'b1, 10'h000, 10'h005, 5'd1};
    vecs[5]  = '{1'b0, 1'b1, 10'h000, 10'h000, 5'd0};
    vecs[6]  = '{1'b1, 1'b0, 10'h050, 10'h050, 5'd1};
    vecs[7]  = '{1'b1, 1'b1, 10'h060, 10'h060, 5'd1};
    vecs[8]  = '{1'b0, 1'b1, 10'h000, 10'h000, 5'd0};
    vecs[9]  = '{1'b1, 1'b1, 10'h070, 10'h070, 5'd1};
    vecs[10] = '{1'b0, 1'b1, 10'h000, 10'h000, 5'd0};
    vecs[11] = '{1'b0, 1'b0, 10'h1AB, 10'h000, 5'd0};

    bus.push = 1'b0;
    bus.pop  = 1'b0;
    bus.din  = '0;
    reset    = 1'b1;
    repeat (2) @(negedge clk);
    chk_state("reset", 10'h000, 5'd0);
    chk("reset.ovf", 32'(bus.ovf), 32'd0);
    chk("reset.udf", 32'(bus.udf), 32'd0);
    reset = 1'b0;
    @(negedge clk);

    // Directed table: basic LIFO order and tail-call replace
    for (int i = 0; i < 12; i++) begin
      step(vecs[i].push, vecs[i].pop, vecs[i].din);
      chk_state($sformatf("vec%0d", i), vecs[i].dout, vecs[i].level);
    end
    chk("vec.udf_after_pushpop_empty", 32'(bus.udf), 32'd0);
    chk("vec.ovf", 32'(bus.ovf), 32'd0);

    // Fill to full, then overflow attempt
    for (int i = 0; i < 16; i++) step(1'b1, 1'b0, 10'(10'h100 + i));
    chk_state("fill", 10'h10F, 5'd16);
    chk("fill.ovf", 32'(bus.ovf), 32'd0);
    step(1'b1, 1'b0, 10'h2AA);
    chk_state("ovf_push", 10'h10F, 5'd16);
    chk("ovf_push.ovf", 32'(bus.ovf), 32'(ERR));
    for (int i = 15; i >= 0; i--) begin
      chk($sformatf("drain%0d.dout", i), 32'(bus.dout), 32'(10'h100 + i));
      step(1'b0, 1'b1, 10'h000);
    end
    chk_state("drained", 10'h000, 5'd0);

    // Underflow, then a push that leaves udf sticky
    step(1'b0, 1'b1, 10'h000);
    chk_state("udf_pop", 10'h000, 5'd0);
    chk("udf_pop.udf", 32'(bus.udf), 32'(ERR));
    step(1'b1, 1'b0, 10'h001);
    chk_state("udf_push", 10'h001, 5'd1);
    chk("udf_push.udf", 32'(bus.udf), 32'(ERR));
    chk("udf_push.ovf", 32'(bus.ovf), 32'(ERR));

    // Asynchronous reset in the middle of the low phase with a push pending
    step(1'b1, 1'b0, 10'h011);
    step(1'b1, 1'b0, 10'h022);
    chk_state("pre_rst", 10'h022, 5'd3);
    bus.push = 1'b1;
    bus.din  = 10'h155;
    #2;
    reset = 1'b1;
    #1;
    chk_state("async_rst", 10'h000, 5'd0);
    chk("async_rst.ovf", 32'(bus.ovf), 32'd0);
    chk("async_rst.udf", 32'(bus.udf), 32'd0);
    @(negedge clk);
    chk_state("rst_hold", 10'h000, 5'd0);
    bus.push = 1'b0;
    reset    = 1'b0;
    @(negedge clk);
    chk_state("rst_release", 10'h000, 5'd0);

    // Random run against a queue LIFO; push bias rotates to reach full and empty
    for (int c = 0; c < 2000; c++) begin
      int   pp;
      logic p, q;
      logic [9:0] d;
      logic [9:0] exp_d;
      case ((c / 150) % 3)
        0:       pp = 75;
        1:       pp = 50;
        default: pp = 25;
      endcase
      p = ($urandom_range(0, 99) < pp);
      q = ($urandom_range(0, 99) < (100 - pp));
      d = 10'($urandom_range(0, 1023));
      if (p && q) begin
        if (model.size() > 0) model[model.size() - 1] = d;
        else                  model.push_back(d);
      end else if (p) begin
        if (model.size() < 16) model.push_back(d);
      end else if (q) begin
        if (model.size() > 0) void'(model.pop_back());
      end
      step(p, q, d);
      exp_d = (model.size() > 0) ? model[model.size() - 1] : 10'h000;
      n_checks++;
      if (bus.dout !== exp_d || bus.level !== 5'(model.size())) begin
        n_err++;
        $display("FAIL rand%0d: dout 0x%0h level %0d expected dout 0x%0h level %0d",
                 c, bus.dout, bus.level, exp_d, model.size());
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
